reg_file_32x64: RTL and testbench



---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_32x64_if.sv | 22 ++
 rtl/reg_file_32x64_mux32to1_64.sv | 10 +
 rtl/reg_file_32x64.sv | 84 ++++++++
 tb/tb_reg_file_32x64.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and types for the 32x64 register file
package reg_file_pkg;
    localparam int REG_DATA_W = 64;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_32x64_if.sv
// rtl/reg_file_32x64_if.sv - write/read bus bundle between decode and the register file
interface reg_file_32x64_if;
    import reg_file_pkg::*;

    logic      write;
    reg_addr_t wrAddr;
    reg_data_t wrData;
    reg_addr_t rdAddrA;
    reg_addr_t rdAddrB;
    reg_data_t rdDataA;
    reg_data_t rdDataB;

    modport master (
        output write, wrAddr, wrData, rdAddrA, rdAddrB,
        input  rdDataA, rdDataB
    );

    modport slave (
        input  write, wrAddr, wrData, rdAddrA, rdAddrB,
        output rdDataA, rdDataB
    );
endinterface

// File: rtl/reg_file_32x64_mux32to1_64.sv
// rtl/reg_file_32x64_mux32to1_64.sv - 64-bit 32:1 combinational read multiplexer
module mux32to1_64
    import reg_file_pkg::*;
(
    input  logic [REG_COUNT-1:0][REG_DATA_W-1:0] data_i,
    input  reg_addr_t                            sel_i,
    output reg_data_t                            data_o
);
    assign data_o = data_i[sel_i];
endmodule

// File: rtl/reg_file_32x64.sv
// rtl/reg_file_32x64.sv - 32x64 register file, one sync write port, two async read ports
// Build option: ZERO_REG_EN makes register 31 a hardwired zero.
module reg_file_32x64
    import reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      write,
    input  logic      reset,
    input  reg_addr_t wrAddr,
    input  reg_data_t wrData,
    input  reg_addr_t rdAddrA,
    input  reg_addr_t rdAddrB,
    output reg_data_t rdDataA,
    output reg_data_t rdDataB
);
    reg_data_t reg0,  reg1,  reg2,  reg3,  reg4,  reg5,  reg6,  reg7;
    reg_data_t reg8,  reg9,  reg10, reg11, reg12, reg13, reg14, reg15;
    reg_data_t reg16, reg17, reg18, reg19, reg20, reg21, reg22, reg23;
    reg_data_t reg24, reg25, reg26, reg27, reg28, reg29, reg30, reg31;

    logic [REG_COUNT-1:0] wr_en;

    always_comb begin
        wr_en = '0;
        if (write) wr_en[wrAddr] = 1'b1;
`ifdef ZERO_REG_EN
        wr_en[REG_COUNT-1] = 1'b0;
`endif
    end

    // Reset wins over the write enable on every register.
    always_ff @(posedge clk) if (reset) reg0  <= '0; else if (wr_en[0])  reg0  <= wrData;
    always_ff @(posedge clk) if (reset) reg1  <= '0; else if (wr_en[1])  reg1  <= wrData;
    always_ff @(posedge clk) if (reset) reg2  <= '0; else if (wr_en[2])  reg2  <= wrData;
    always_ff @(posedge clk) if (reset) reg3  <= '0; else if (wr_en[3])  reg3  <= wrData;
    always_ff @(posedge clk) if (reset) reg4  <= '0; else if (wr_en[4])  reg4  <= wrData;
    always_ff @(posedge clk) if (reset) reg5  <= '0; else if (wr_en[5])  reg5  <= wrData;
    always_ff @(posedge clk) if (reset) reg6  <= '0; else if (wr_en[6])  reg6  <= wrData;
    always_ff @(posedge clk) if (reset) reg7  <= '0; else if (wr_en[7])  reg7  <= wrData;
    always_ff @(posedge clk) if (reset) reg8  <= '0; else if (wr_en[8])  reg8  <= wrData;
    always_ff @(posedge clk) if (reset) reg9  <= '0; else if (wr_en[9])  reg9  <= wrData;
    always_ff @(posedge clk) if (reset) reg10 <= '0; else if (wr_en[10]) reg10 <= wrData;
    always_ff @(posedge clk) if (reset) reg11 <= '0; else if (wr_en[11]) reg11 <= wrData;
    always_ff @(posedge clk) if (reset) reg12 <= '0; else if (wr_en[12]) reg12 <= wrData;
    always_ff @(posedge clk) if (reset) reg13 <= '0; else if (wr_en[13]) reg13 <= wrData;
    always_ff @(posedge clk) if (reset) reg14 <= '0; else if (wr_en[14]) reg14 <= wrData;
    always_ff @(posedge clk) if (reset) reg15 <= '0; else if (wr_en[15]) reg15 <= wrData;
    always_ff @(posedge clk) if (reset) reg16 <= '0; else if (wr_en[16]) reg16 <= wrData;
    always_ff @(posedge clk) if (reset) reg17 <= '0; else if (wr_en[17]) reg17 <= wrData;
    always_ff @(posedge clk) if (reset) reg18 <= '0; else if (wr_en[18]) reg18 <= wrData;
    always_ff @(posedge clk) if (reset) reg19 <= '0; else if (wr_en[19]) reg19 <= wrData;
    always_ff @(posedge clk) if (reset) reg20 <= '0; else if (wr_en[20]) reg20 <= wrData;
    always_ff @(posedge clk) if (reset) reg21 <= '0; else if (wr_en[21]) reg21 <= wrData;
    always_ff @(posedge clk) if (reset) reg22 <= '0; else if (wr_en[22]) reg22 <= wrData;
    always_ff @(posedge clk) if (reset) reg23 <= '0; else if (wr_en[23]) reg23 <= wrData;
    always_ff @(posedge clk) if (reset) reg24 <= '0; else if (wr_en[24]) reg24 <= wrData;
    always_ff @(posedge clk) if (reset) reg25 <= '0; else if (wr_en[25]) reg25 <= wrData;
    always_ff @(posedge clk) if (reset) reg26 <= '0; else if (wr_en[26]) reg26 <= wrData;
    always_ff @(posedge clk) if (reset) reg27 <= '0; else if (wr_en[27]) reg27 <= wrData;
    always_ff @(posedge clk) if (reset) reg28 <= '0; else if (wr_en[28]) reg28 <= wrData;
    always_ff @(posedge clk) if (reset) reg29 <= '0; else if (wr_en[29]) reg29 <= wrData;
    always_ff @(posedge clk) if (reset) reg30 <= '0; else if (wr_en[30]) reg30 <= wrData;
    always_ff @(posedge clk) if (reset) reg31 <= '0; else if (wr_en[31]) reg31 <= wrData;

    logic [REG_COUNT-1:0][REG_DATA_W-1:0] regs_all;

    assign regs_all = {reg31, reg30, reg29, reg28, reg27, reg26, reg25, reg24,
                       reg23, reg22, reg21, reg20, reg19, reg18, reg17, reg16,
                       reg15, reg14, reg13, reg12, reg11, reg10, reg9,  reg8,
                       reg7,  reg6,  reg5,  reg4,  reg3,  reg2,  reg1,  reg0};

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    mux32to1_64 u_mux_a (
        .data_i (regs_all),
        .sel_i  (rdAddrA),
        .data_o (rdDataA)
    );

    mux32to1_64 u_mux_b (
        .data_i (regs_all),
        .sel_i  (rdAddrB),
        .data_o (rdDataB)
    );
endmodule

// File: tb/tb_reg_file_32x64.sv
// tb/tb_reg_file_32x64.sv - directed self-checking bench for reg_file_32x64
module tb_reg_file_32x64;
    import reg_file_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    reg_data_t exp_q [32];

    reg_file_32x64_if bus ();

    reg_file_32x64 dut (
        .clk     (clk),
        .write   (bus.write),
        .reset   (reset),
        .wrAddr  (bus.wrAddr),
        .wrData  (bus.wrData),
        .rdAddrA (bus.rdAddrA),
        .rdAddrB (bus.rdAddrB),
        .rdDataA (bus.rdDataA),
        .rdDataB (bus.rdDataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic reg_data_t pat(input int i);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'hC0DE_0000 + i;
        lo = 32'h1234_5678 ^ (i * 32'h0101_0101);
        return {hi, lo};
    endfunction

    function automatic reg_data_t probe(input int idx);
        case (idx)
            0:  return dut.reg0;   1:  return dut.reg1;   2:  return dut.reg2;   3:  return dut.reg3;
            4:  return dut.reg4;   5:  return dut.reg5;   6:  return dut.reg6;   7:  return dut.reg7;
            8:  return dut.reg8;   9:  return dut.reg9;   10: return dut.reg10;  11: return dut.reg11;
            12: return dut.reg12;  13: return dut.reg13;  14: return dut.reg14;  15: return dut.reg15;
            16: return dut.reg16;  17: return dut.reg17;  18: return dut.reg18;  19: return dut.reg19;
            20: return dut.reg20;  21: return dut.reg21;  22: return dut.reg22;  23: return dut.reg23;
            24: return dut.reg24;  25: return dut.reg25;  26: return dut.reg26;  27: return dut.reg27;
            28: return dut.reg28;  29: return dut.reg29;  30: return dut.reg30;  default: return dut.reg31;
        endcase
    endfunction

    task automatic check(input string tag, input int idx, input reg_data_t obs, input reg_data_t expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        foreach (exp_q[k]) exp_q[k] = '0;

        // Reset with a competing write to 31
        reset       = 1'b1;
        bus.write   = 1'b1;
        bus.wrAddr  = 5'd31;
        bus.wrData  = '0;
        bus.rdAddrA = '0;
        bus.rdAddrB = '0;
        tick();
        reset     = 1'b0;
        bus.write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("reset_reg", i, probe(i), 64'h0);
            bus.rdAddrA = i[4:0];
            bus.rdAddrB = 5'(31 - i);
            #1;
            check("reset_rdA", i, bus.rdDataA, 64'h0);
            check("reset_rdB", i, bus.rdDataB, 64'h0);
        end

        // Sequential fill, reads trail the write address by one
        bus.write = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.wrAddr  = i[4:0];
            bus.wrData  = pat(i);
            bus.rdAddrA = 5'((i + 31) % 32);
            bus.rdAddrB = 5'((i + 31) % 32);
            tick();
`ifdef ZERO_REG_EN
            if (i != 31) exp_q[i] = pat(i);
`else
            exp_q[i] = pat(i);
`endif
            check("fill_reg", i, probe(i), exp_q[i]);
            check("fill_rdA", i, bus.rdDataA, exp_q[(i + 31) % 32]);
            check("fill_rdB", i, bus.rdDataB, exp_q[(i + 31) % 32]);
        end

        // Write disabled: garbage on the data bus must not land anywhere
        bus.write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.wrAddr  = i[4:0];
            bus.wrData  = ~pat(i);
            bus.rdAddrA = i[4:0];
            bus.rdAddrB = 5'(31 - i);
            tick();
            check("hold_rdA", i, bus.rdDataA, exp_q[i]);
            check("hold_rdB", i, bus.rdDataB, exp_q[31 - i]);
            check("hold_reg", i, probe(i), exp_q[i]);
        end

        // Read/write collision on register 5
        bus.write  = 1'b1;
        bus.wrAddr = 5'd5;
        bus.wrData = 64'h1111;
        tick();
        exp_q[5]    = 64'h1111;
        bus.wrData  = 64'hDEAD_BEEF_0000_0005;
        bus.rdAddrA = 5'd5;
        #1;
        check("coll_before", 5, bus.rdDataA, 64'h1111);
        tick();
        bus.write = 1'b0;
        exp_q[5]  = 64'hDEAD_BEEF_0000_0005;
        check("coll_after", 5, bus.rdDataA, 64'hDEAD_BEEF_0000_0005);

        // Dual read, same then different address
        bus.rdAddrA = 5'd3;
        bus.rdAddrB = 5'd3;
        #1;
        check("dual_same_A", 3, bus.rdDataA, pat(3));
        check("dual_same_B", 3, bus.rdDataB, pat(3));
        bus.rdAddrB = 5'd7;
        #1;
        check("dual_diff_A", 3, bus.rdDataA, pat(3));
        check("dual_diff_B", 7, bus.rdDataB, pat(7));

        // Reset in the middle of traffic, with a write pending to 10
        reset       = 1'b1;
        bus.write   = 1'b1;
        bus.wrAddr  = 5'd10;
        bus.wrData  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.rdAddrA = 5'd10;
        #1;
        check("pre_rst_reg10", 10, bus.rdDataA, pat(10));
        tick();
        reset     = 1'b0;
        bus.write = 1'b0;
        check("rst_rd10", 10, bus.rdDataA, 64'h0);
        for (int i = 0; i < 32; i++) begin
            check("rst2_reg", i, probe(i), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
